// File: rtl/hour_counter_if.sv
// Hour counter bus: minute/second tick inputs, manual adjust and display
// mode controls, plus the hour/display/pm/day_tick outputs.
// Optional macro HOUR_CHIME_EN adds the chime output to the bus.
interface hour_counter_if #(
    parameter int HW = 5
) ();
    logic          min_tick;
    logic          sec_tick;
    logic          switch_hour;
    logic          mode_12h;
    logic [HW-1:0] hour_count;
    logic [HW-1:0] hour_disp;
    logic          pm;
    logic          day_tick;
`ifdef HOUR_CHIME_EN
    logic          chime;

    modport master (
        output min_tick, sec_tick, switch_hour, mode_12h,
        input  hour_count, hour_disp, pm, day_tick, chime
    );

    modport slave (
        input  min_tick, sec_tick, switch_hour, mode_12h,
        output hour_count, hour_disp, pm, day_tick, chime
    );
`else
    modport master (
        output min_tick, sec_tick, switch_hour, mode_12h,
        input  hour_count, hour_disp, pm, day_tick
    );

    modport slave (
        input  min_tick, sec_tick, switch_hour, mode_12h,
        output hour_count, hour_disp, pm, day_tick
    );
`endif
endinterface

// File: rtl/hour_counter.sv
// Hour-of-day counter (0..23) for the digital clock chain.
// Counts minute-wrap pulses in normal mode; while switch_hour is held the
// hour advances once on the switch rising edge and once per sec_tick.
// Provides 12h/24h display, pm flag and a day_tick on the natural 23->0 wrap.
// Optional macro HOUR_CHIME_EN adds a chime pulse on every minute-driven
// hour change.
module hour_counter #(
    parameter int RESET_HOUR = 0,
    parameter int HW         = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    hour_counter_if.slave       bus
);

    logic [HW-1:0] r_hour;
    logic          r_sw_prev;
    logic          r_day_tick;

    logic          w_sw_rise;
    logic          w_adj_inc;
    logic          w_norm_inc;
    logic          w_inc;
    logic          w_at_23;
    logic [HW-1:0] w_hour_inc;
    logic [HW-1:0] w_disp;

    // A held switch only advances on its rising edge or on sec_tick; an edge
    // coinciding with sec_tick still yields a single increment.
    assign w_sw_rise  = bus.switch_hour & ~r_sw_prev;
    assign w_adj_inc  = bus.switch_hour & (w_sw_rise | bus.sec_tick);
    // min_tick is deliberately dropped while adjusting.
    assign w_norm_inc = ~bus.switch_hour & bus.min_tick;
    assign w_inc      = w_adj_inc | w_norm_inc;
    assign w_at_23    = (r_hour == HW'(23));
    // Anything at or above 23 (including unreachable values) wraps to 0.
    assign w_hour_inc = (r_hour >= HW'(23)) ? '0 : r_hour + HW'(1);

    // Hour register plus the switch edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hour    <= HW'(RESET_HOUR);
            r_sw_prev <= 1'b0;
        end else begin
            r_sw_prev <= bus.switch_hour;
            if (w_inc) begin
                r_hour <= w_hour_inc;
            end
        end
    end

    // day_tick marks only the natural, minute-driven 23->0 wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_day_tick <= 1'b0;
        end else begin
            r_day_tick <= w_norm_inc & w_at_23;
        end
    end

    // Display hour: 0 shows as 12, 13..23 fold down by 12 in 12-hour mode.
    always_comb begin
        w_disp = r_hour;
        if (bus.mode_12h) begin
            if (r_hour == '0) begin
                w_disp = HW'(12);
            end else if (r_hour > HW'(12)) begin
                w_disp = r_hour - HW'(12);
            end
        end
    end

    assign bus.hour_count = r_hour;
    assign bus.hour_disp  = w_disp;
    assign bus.pm         = (r_hour >= HW'(12));
    assign bus.day_tick   = r_day_tick;

`ifdef HOUR_CHIME_EN
    logic r_chime;

    // Chime accompanies every minute-driven hour change, never manual ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chime <= 1'b0;
        end else begin
            r_chime <= w_norm_inc;
        end
    end

    assign bus.chime = r_chime;
`endif

endmodule

// File: tb/tb_hour_counter.sv
// Self-checking bench for hour_counter: directed scenarios plus randomized
// stimulus compared against an integer-arithmetic reference model.
// Chime checks compile in when HOUR_CHIME_EN is defined.
module tb_hour_counter;

    localparam int HW = 5;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_errors;

    // Reference model state
    int m_hour;
    bit m_prev_sw;
    bit m_day;
    bit m_chime;

    hour_counter_if #(.HW(HW)) bus ();

    hour_counter #(
        .RESET_HOUR (0),
        .HW         (HW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int disp_of(input int h, input bit m12);
        if (!m12) return h;
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    // One clock edge; the model advances using the inputs present at the edge.
    task automatic step();
        bit inc_n;
        bit inc_a;
        @(posedge clk);
        inc_n   = !bus.switch_hour && bus.min_tick;
        inc_a   = bus.switch_hour && (!m_prev_sw || bus.sec_tick);
        m_day   = inc_n && (m_hour == 23);
        m_chime = inc_n;
        if (inc_n || inc_a) m_hour = (m_hour + 1) % 24;
        m_prev_sw = bus.switch_hour;
        #1;
    endtask

    task automatic idle_inputs();
        bus.min_tick    = 1'b0;
        bus.sec_tick    = 1'b0;
        bus.switch_hour = 1'b0;
        bus.mode_12h    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        m_hour = 0; m_prev_sw = 1'b0; m_day = 1'b0; m_chime = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic min_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            bus.min_tick = 1'b1;
            step();
            bus.min_tick = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        m_hour = 0; m_prev_sw = 1'b0; m_day = 1'b0; m_chime = 1'b0;
        #2;
        n_checks++;
        if (bus.hour_count !== HW'(0)) begin
            n_errors++;
            $display("FAIL reset_hold_hour: got %0d expected 0", bus.hour_count);
        end
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();
        n_checks++;
        if (bus.hour_count !== HW'(0)) begin
            n_errors++;
            $display("FAIL reset_hour: got %0d expected 0", bus.hour_count);
        end
        n_checks++;
        if (bus.hour_disp !== HW'(0)) begin
            n_errors++;
            $display("FAIL reset_disp: got %0d expected 0", bus.hour_disp);
        end
        n_checks++;
        if (bus.pm !== 1'b0 || bus.day_tick !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_pm_day: got pm=%b day=%b expected 0 0", bus.pm, bus.day_tick);
        end
`ifdef HOUR_CHIME_EN
        n_checks++;
        if (bus.chime !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_chime: got %b expected 0", bus.chime);
        end
`endif
    endtask

    task automatic test_normal();
        do_reset();
        min_pulses(23);
        n_checks++;
        if (bus.hour_count !== HW'(23) || bus.pm !== 1'b1) begin
            n_errors++;
            $display("FAIL normal_23: got hour=%0d pm=%b expected 23 1", bus.hour_count, bus.pm);
        end
        n_checks++;
        if (bus.hour_disp !== HW'(23)) begin
            n_errors++;
            $display("FAIL normal_disp24: got %0d expected 23", bus.hour_disp);
        end
        bus.mode_12h = 1'b1;
        #1;
        n_checks++;
        if (bus.hour_disp !== HW'(11) || bus.hour_count !== HW'(23)) begin
            n_errors++;
            $display("FAIL normal_disp12: got disp=%0d hour=%0d expected 11 23", bus.hour_disp, bus.hour_count);
        end
        bus.min_tick = 1'b1;
        step();
        bus.min_tick = 1'b0;
        n_checks++;
        if (bus.hour_count !== HW'(0) || bus.day_tick !== 1'b1) begin
            n_errors++;
            $display("FAIL normal_wrap: got hour=%0d day=%b expected 0 1", bus.hour_count, bus.day_tick);
        end
        n_checks++;
        if (bus.hour_disp !== HW'(12) || bus.pm !== 1'b0) begin
            n_errors++;
            $display("FAIL normal_wrap_disp: got disp=%0d pm=%b expected 12 0", bus.hour_disp, bus.pm);
        end
        step();
        n_checks++;
        if (bus.day_tick !== 1'b0) begin
            n_errors++;
            $display("FAIL normal_day_one_cycle: got %b expected 0", bus.day_tick);
        end
        bus.mode_12h = 1'b0;
    endtask

    task automatic test_adjust();
        do_reset();
        min_pulses(5);
        bus.switch_hour = 1'b1;
        step();
        n_checks++;
        if (bus.hour_count !== HW'(6)) begin
            n_errors++;
            $display("FAIL adjust_edge: got %0d expected 6", bus.hour_count);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            bus.sec_tick = 1'b1;
            step();
            bus.sec_tick = 1'b0;
        end
        n_checks++;
        if (bus.hour_count !== HW'(9)) begin
            n_errors++;
            $display("FAIL adjust_ticks: got %0d expected 9", bus.hour_count);
        end
        min_pulses(2);
        n_checks++;
        if (bus.hour_count !== HW'(9)) begin
            n_errors++;
            $display("FAIL adjust_min_ignored: got %0d expected 9", bus.hour_count);
        end
        bus.switch_hour = 1'b0;
        step();
        n_checks++;
        if (bus.hour_count !== HW'(9)) begin
            n_errors++;
            $display("FAIL adjust_fall: got %0d expected 9", bus.hour_count);
        end
        min_pulses(1);
        n_checks++;
        if (bus.hour_count !== HW'(10)) begin
            n_errors++;
            $display("FAIL adjust_resume: got %0d expected 10", bus.hour_count);
        end
    endtask

    task automatic test_adjust_wrap();
        do_reset();
        min_pulses(22);
        bus.switch_hour = 1'b1;
        bus.sec_tick    = 1'b1;
        step();
        bus.sec_tick = 1'b0;
        n_checks++;
        if (bus.hour_count !== HW'(23)) begin
            n_errors++;
            $display("FAIL wrap_single_inc: got %0d expected 23", bus.hour_count);
        end
        step();
        bus.sec_tick = 1'b1;
        step();
        bus.sec_tick = 1'b0;
        n_checks++;
        if (bus.hour_count !== HW'(0) || bus.day_tick !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_manual: got hour=%0d day=%b expected 0 0", bus.hour_count, bus.day_tick);
        end
`ifdef HOUR_CHIME_EN
        n_checks++;
        if (bus.chime !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_manual_chime: got %b expected 0", bus.chime);
        end
`endif
        step();
        n_checks++;
        if (bus.day_tick !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_manual_day_after: got %b expected 0", bus.day_tick);
        end
        bus.switch_hour = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        min_pulses(13);
        bus.switch_hour = 1'b1;
        step();
        n_checks++;
        if (bus.hour_count !== HW'(14)) begin
            n_errors++;
            $display("FAIL async_pre: got %0d expected 14", bus.hour_count);
        end
        #2;
        rst_n = 1'b0;
        m_hour = 0; m_prev_sw = 1'b0; m_day = 1'b0; m_chime = 1'b0;
        #1;
        n_checks++;
        if (bus.hour_count !== HW'(0)) begin
            n_errors++;
            $display("FAIL async_immediate: got %0d expected 0", bus.hour_count);
        end
        #1;
        rst_n = 1'b1;
        step();
        n_checks++;
        if (bus.hour_count !== HW'(1)) begin
            n_errors++;
            $display("FAIL async_fresh_edge: got %0d expected 1", bus.hour_count);
        end
        step();
        n_checks++;
        if (bus.hour_count !== HW'(1)) begin
            n_errors++;
            $display("FAIL async_held: got %0d expected 1", bus.hour_count);
        end
        bus.switch_hour = 1'b0;
    endtask

`ifdef HOUR_CHIME_EN
    task automatic test_chime();
        do_reset();
        min_pulses(7);
        bus.min_tick = 1'b1;
        step();
        bus.min_tick = 1'b0;
        n_checks++;
        if (bus.chime !== 1'b1 || bus.hour_count !== HW'(8)) begin
            n_errors++;
            $display("FAIL chime_min: got chime=%b hour=%0d expected 1 8", bus.chime, bus.hour_count);
        end
        step();
        n_checks++;
        if (bus.chime !== 1'b0) begin
            n_errors++;
            $display("FAIL chime_one_cycle: got %b expected 0", bus.chime);
        end
        bus.switch_hour = 1'b1;
        step();
        n_checks++;
        if (bus.chime !== 1'b0 || bus.hour_count !== HW'(9)) begin
            n_errors++;
            $display("FAIL chime_manual: got chime=%b hour=%0d expected 0 9", bus.chime, bus.hour_count);
        end
        bus.switch_hour = 1'b0;
    endtask
`endif

    task automatic test_random();
        int errs_before;
        do_reset();
        errs_before = n_errors;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) bus.switch_hour = ~bus.switch_hour;
            bus.min_tick = ($urandom_range(0, 2) == 0);
            bus.sec_tick = ($urandom_range(0, 3) == 0);
            bus.mode_12h = 1'($urandom);
            step();
            n_checks++;
            if (bus.hour_count !== HW'(m_hour) || bus.day_tick !== m_day) begin
                n_errors++;
                if (n_errors - errs_before < 10)
                    $display("FAIL rand_hour_day cyc %0d: got hour=%0d day=%b expected %0d %b",
                             i, bus.hour_count, bus.day_tick, m_hour, m_day);
            end
            n_checks++;
            if (bus.hour_disp !== HW'(disp_of(m_hour, bus.mode_12h)) || bus.pm !== (m_hour >= 12)) begin
                n_errors++;
                if (n_errors - errs_before < 10)
                    $display("FAIL rand_disp_pm cyc %0d: got disp=%0d pm=%b expected %0d %b",
                             i, bus.hour_disp, bus.pm, disp_of(m_hour, bus.mode_12h), (m_hour >= 12));
            end
`ifdef HOUR_CHIME_EN
            n_checks++;
            if (bus.chime !== m_chime) begin
                n_errors++;
                if (n_errors - errs_before < 10)
                    $display("FAIL rand_chime cyc %0d: got %b expected %b", i, bus.chime, m_chime);
            end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_normal();
        test_adjust();
        test_adjust_wrap();
        test_async_reset();
`ifdef HOUR_CHIME_EN
        test_chime();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hour_counter.md
Name: hour_counter

Overview:
- Downstream stage of the minute counter in the digital clock chain.
- Consumes the minute-wrap pulse min_tick and maintains the hour of day, 0..23.
- Provides manual fast-set via switch_hour, paced by sec_tick.
- Produces 12h/24h display values and a day_tick pulse for a future day/date stage.

Parameters:
- RESET_HOUR, 0, hour loaded on reset; legal range 0..23.
- HW, 5, width of the hour_count and hour_disp outputs; must be >= 5.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- min_tick  input  1  one-cycle pulse from minute_counter on minute wrap 59->0
- sec_tick  input  1  one-cycle pulse, 1 Hz, from the seconds stage; paces manual adjust
- switch_hour  input  1  manual adjust request, level, already debounced
- mode_12h  input  1  1 = 12-hour display, 0 = 24-hour display
- hour_count  output  HW  registered hour of day, 0..23
- hour_disp  output  HW  display hour, derived combinationally from hour_count and mode_12h
- pm  output  1  1 when hour_count >= 12
- day_tick  output  1  registered one-cycle pulse on natural 23->0 wrap

Behaviour:
- Reset (rst_n low, async): hour_count=RESET_HOUR, day_tick=0, internal switch_hour edge register=0. hour_disp and pm follow the combinational rules below.
- Increment rule: next = (hour_count==23) ? 0 : hour_count+1. No other arithmetic touches hour_count.
- Mode NORMAL (switch_hour low):
  - min_tick high in cycle N -> hour_count incremented, visible at N+1.
  - sec_tick is ignored.
- Mode ADJUST (switch_hour high):
  - Rising edge of switch_hour (switch_hour=1, registered previous=0) -> one immediate increment.
  - Each subsequent sec_tick while switch_hour stays high -> one increment.
  - If the rising edge and sec_tick fall in the same cycle -> exactly one increment.
  - min_tick is ignored while switch_hour is high; the minute is lost by design.
- At most one increment per cycle under all input combinations.
- day_tick:
  - Set to 1 for exactly the cycle in which hour_count transitions 23->0 due to min_tick in NORMAL mode.
  - A 23->0 wrap caused by manual adjust never asserts day_tick.
  - Cleared to 0 in every other cycle.
- hour_disp:
  - mode_12h=0: hour_disp = hour_count.
  - mode_12h=1: hour_count 0 -> 12; 1..12 -> unchanged; 13..23 -> hour_count-12.
- pm = (hour_count >= 12) regardless of mode_12h.
- A mode_12h change affects hour_disp in the same cycle and never alters hour_count.
- switch_hour falling edge: no action; the next min_tick resumes normal counting.
- Reset asserted mid-adjust or mid-pulse: state returns to reset values immediately. After release, a switch_hour still held high counts as a fresh rising edge on the first clock and increments once.
- Out-of-range internal value (not reachable; guards against X/injection): any value >23 increments to 0.

Optional Feature:
- Macro HOUR_CHIME_EN.
- Defined:
  - Adds output chime (1 bit), a registered one-cycle pulse coincident with every hour_count change caused by min_tick, including 23->0.
  - Manual adjust never chimes.
  - chime resets to 0.
- Not defined: no chime port and no chime logic; the module is otherwise identical.

Test Plan:
- Reset/default: hold rst_n=0 with RESET_HOUR=0, then release -> hour_count=0, hour_disp=0, pm=0, day_tick=0.
- Normal counting: 23 min_tick pulses, then observe -> hour_count=23, pm=1, hour_disp=23 (mode_12h=0) / 11 (mode_12h=1). One more min_tick -> hour_count=0, day_tick=1 for exactly one cycle, hour_disp=12 in 12h mode.
- Manual adjust: from hour 5, raise switch_hour, hold for 3 sec_tick pulses -> hour_count=9 (1 edge + 3 ticks). min_tick pulses during the hold leave it at 9. Lower switch_hour, then 1 min_tick -> 10.
- Adjust wrap: from hour 22, raise switch_hour with sec_tick in the same cycle -> 23 (single increment). Next sec_tick -> 0 with day_tick remaining 0.
- Async reset mid-adjust: at hour 14 with switch_hour high, pulse rst_n low between clock edges -> hour_count=0 immediately. Release with switch_hour still high -> 1 on the next edge.
- HOUR_CHIME_EN build: min_tick at hour 7 -> chime=1 for one cycle with hour_count=8. Manual adjust from 8 -> chime stays 0.
